tick_gen_multi: RTL

- Parametrised multi-channel clock divider and tick generator for the game logic.
- Replaces the single fixed-ratio divider with NUM_CH independent channels.
- Each channel has a runtime-loadable divide value, a per-channel enable, and two outputs: a 50%-duty square wave and a one-cycle tick strobe.
- Sits at top level next to the board clock; feeds the game-step, animation and 1 s timer domains.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_gen_ch.sv | 65 ++++++
 rtl/tick_gen_multi.sv | 47 ++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen_pkg : clock constants and divide helpers for tick_gen     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tick_gen_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned DIV_10MS = 499_999;     // 5 ms half-period
  localparam int unsigned DIV_1S   = 49_999_999;
  localparam int unsigned DIV_ANIM = 4_999_999;

  // Divide value giving a square wave of hz on clk_out
  function automatic int unsigned div_for_hz(input int unsigned hz);
    return CLK_HZ / (2 * hz) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen_ch : one divider channel (square wave + wrap strobe)      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_10MS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_out;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= DEFAULT_DIV;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      // A load lands in the divide register even when a clear wins everything else
      if (ld) begin
        r_div <= ld_val;
      end
      if (clr) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else if (ld) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (!en) begin
        r_tick <= 1'b0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_clk_out <= ~r_clk_out;
        r_tick    <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/tick_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen_multi : NUM_CH independent runtime-loadable tick dividers |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DIV_10MS),
  parameter int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] w_ld;

  // Out-of-range load_ch matches no channel, so the load simply vanishes
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_ld[i] = load && (load_ch == CH_W'(i));

    tick_gen_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[i]),
      .clr     (sync_clr),
      .ld      (w_ld[i]),
      .ld_val  (load_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
`default_nettype wire
